// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port data RAM between the instruction-fetch port
//   (read-only) and the load/store unit. One transaction is in flight at a
//   time. Simultaneous requests are resolved round-robin against the port
//   that was granted last. A granted access walks IDLE -> ISSUE -> WAIT ->
//   RESP. WAIT absorbs the RAM read latency. RESP pulses the owner's rvalid
//   for one cycle. Every output comes straight from a register.
//
// Parameters
//   ADDR_W      word address width (RAM depth 2**ADDR_W)
//   DATA_W      data width, multiple of 8
//   RD_LATENCY  cycles from mem_en at the RAM to valid mem_rdata (1..7)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   if_req/if_addr            fetch read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata fetch accept pulse, data-valid pulse, read data
//   ls_req/ls_we/ls_be        LSU request, store flag, store byte enables
//   ls_addr/ls_wdata          LSU word address and store data
//   ls_gnt/ls_rvalid/ls_rdata LSU accept pulse, done pulse, load data (0 for stores)
//   mem_en/mem_we             RAM access strobe and byte write enables
//   mem_addr/mem_wdata        RAM word address and write data
//   mem_rdata                 RAM read data, RD_LATENCY cycles after mem_en
module mem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  // The counter starts at RD_LATENCY-1. The capture happens on the WAIT
  // cycle where it reads zero, so mem_rdata is taken exactly RD_LATENCY
  // cycles after mem_en was seen by the RAM.
  localparam logic [2:0] WAIT_INIT = 3'(RD_LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              store_q, store_d;

  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic [BE_W-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Byte write enables for an LSU request. A load yields all zeros, so the
  // RAM is never written by a load even if ls_be is non-zero.
  logic [BE_W-1:0]   store_be;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_store_be
    assign store_be[gi] = ls_we & ls_be[gi];
  end

  // The LSU wins when it is the only requester. On a tie it wins only if
  // fetch owned the previous grant.
  logic pick_ls;
  assign pick_ls = ls_req & (~if_req | (last_owner_q == OWNER_IF));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    store_d      = store_q;
    if_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_gnt_d     = 1'b0;
    ls_rvalid_d  = 1'b0;
    ls_rdata_d   = ls_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = '0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          state_d      = ST_ISSUE;
          owner_d      = pick_ls ? OWNER_LS : OWNER_IF;
          last_owner_d = pick_ls ? OWNER_LS : OWNER_IF;
          mem_en_d     = 1'b1;
          if (pick_ls) begin
            ls_gnt_d    = 1'b1;
            store_d     = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_we_d    = store_be;
          end else begin
            if_gnt_d    = 1'b1;
            store_d     = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = WAIT_INIT;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
          if (owner_q == OWNER_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = store_q ? '0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The asynchronous reset clears mem_we at once. A store caught in ISSUE
  // therefore never reaches the RAM, and an in-flight access is dropped
  // without an rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      last_owner_q <= OWNER_IF;
      owner_q      <= OWNER_IF;
      store_q      <= 1'b0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_gnt_q     <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      ls_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      ls_gnt_q     <= ls_gnt_d;
      ls_rvalid_q  <= ls_rvalid_d;
      ls_rdata_q   <= ls_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_gnt    = ls_gnt_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives two mem_arbiter instances.
//   u_dut has RD_LATENCY=1 and sits on a modelled byte-writable RAM. It
//   receives randomized fetch and LSU traffic plus directed scenarios.
//   u_dut3 has RD_LATENCY=3 and covers the longer read-latency path.
//   A transaction-level reference model predicts, per cycle, the grant,
//   strobe and response events and the returned data.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 128;
  localparam int L     = 1;
  localparam int NCYC  = 2600;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0;
  logic [BW-1:0] ls_be = '0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic          if_req3 = 1'b0;
  logic [AW-1:0] if_addr3 = '0;
  logic          if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_en3;
  logic [DW-1:0] if_rdata3, ls_rdata3, mem_wdata3, mem_rdata3;
  logic [BW-1:0] mem_we3;
  logic [AW-1:0] mem_addr3;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(1'b0), .ls_we(1'b0), .ls_be(4'b0), .ls_addr(7'd0), .ls_wdata(32'd0),
    .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // RAM for u_dut: one-cycle read latency. Data outside the valid cycle is
  // a poison pattern, so a mistimed capture shows up as wrong data.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd_data = '0;
  logic          rd_vld = 1'b0;
  logic          ram_init_en = 1'b0;
  logic [AW-1:0] ram_init_addr = '0;
  logic [DW-1:0] ram_init_data = '0;
  always @(posedge clk) begin
    rd_vld <= mem_en;
    if (ram_init_en) ram[ram_init_addr] <= ram_init_data;
    else if (mem_en) begin
      rd_data <= ram[mem_addr];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = rd_vld ? rd_data : 32'hDEAD_BEEF;

  // Read-only RAM for u_dut3: three-cycle latency, content derived from address.
  logic [2:0]    v3 = 3'b0;
  logic [AW-1:0] a3_0 = '0, a3_1 = '0, a3_2 = '0;
  always @(posedge clk) begin
    v3   <= {v3[1:0], mem_en3};
    a3_0 <= mem_addr3;
    a3_1 <= a3_0;
    a3_2 <= a3_1;
  end
  assign mem_rdata3 = v3[2] ? (32'hC0DE_0000 | 32'(a3_2)) : 32'hBAD0_BAD0;

  // Reference model state and per-cycle expected events
  bit [DW-1:0] ref_mem [DEPTH];
  bit          e_if_gnt [NCYC];
  bit          e_ls_gnt [NCYC];
  bit          e_if_rv  [NCYC];
  bit          e_ls_rv  [NCYC];
  bit          e_en     [NCYC];
  bit          e_st     [NCYC];
  bit [BW-1:0] e_we     [NCYC];
  bit [AW-1:0] e_addr   [NCYC];
  bit [DW-1:0] e_wdata  [NCYC];
  bit [DW-1:0] e_if_rd  [NCYC];
  bit [DW-1:0] e_ls_rd  [NCYC];
  bit [DW-1:0] cur_if_rd = '0, cur_ls_rd = '0;
  bit          last_ls = 1'b0;
  int          idle_from = 32'h3FFF_FFFF;
  int          cyc = 0;
  bit          if_pend = 1'b0, ls_pend = 1'b0, hold_both = 1'b0;

  int          n_checks = 0, n_errors = 0;
  int          we_cnt = 0, ls_rv_cnt = 0, if_rv_cyc = 0;
  logic [DW-1:0] last_ls_rd = '0, last_if_rd = '0, saved = '0, rd3 = '0;
  int          g_cyc [$];
  bit          g_ls  [$];
  int          c0 = 0, t_g = -1, t_e = -1, t_v = -1, n_v = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Schedule one granted transaction from the arbitration rules
  task automatic model_grant();
    int  g, r;
    bit  win_ls;
    g = cyc + 1;
    r = cyc + 2 + L;
    if (r + 2 >= NCYC) begin
      $display("FAIL cycle_budget cycle %0d exceeds %0d", r, NCYC);
      $fatal(1);
    end
    win_ls = ls_pend && (!if_pend || !last_ls);
    e_en[g] = 1'b1;
    if (win_ls) begin
      e_ls_gnt[g] = 1'b1;
      e_ls_rv[r]  = 1'b1;
      e_addr[g]   = ls_addr;
      if (ls_we) begin
        e_st[g]    = 1'b1;
        e_we[g]    = ls_be;
        e_wdata[g] = ls_wdata;
        e_ls_rd[r] = '0;
        for (int b = 0; b < BW; b++)
          if (ls_be[b]) ref_mem[ls_addr][8*b +: 8] = ls_wdata[8*b +: 8];
      end else begin
        e_ls_rd[r] = ref_mem[ls_addr];
      end
    end else begin
      e_if_gnt[g] = 1'b1;
      e_if_rv[r]  = 1'b1;
      e_addr[g]   = if_addr;
      e_if_rd[r]  = ref_mem[if_addr];
    end
    last_ls   = win_ls;
    idle_from = cyc + 3 + L;
  endtask

  // One cycle: compare outputs, update requesters, advance the model
  task automatic step(input bit rnd);
    @(negedge clk);
    cyc++;
    check_value("if_gnt", if_gnt, e_if_gnt[cyc]);
    check_value("ls_gnt", ls_gnt, e_ls_gnt[cyc]);
    check_value("if_rvalid", if_rvalid, e_if_rv[cyc]);
    check_value("ls_rvalid", ls_rvalid, e_ls_rv[cyc]);
    check_value("mem_en", mem_en, e_en[cyc]);
    check_value("mem_we", mem_we, e_we[cyc]);
    if (e_en[cyc]) check_value("mem_addr", mem_addr, e_addr[cyc]);
    if (e_st[cyc]) check_value("mem_wdata", mem_wdata, e_wdata[cyc]);
    if (e_if_rv[cyc]) cur_if_rd = e_if_rd[cyc];
    if (e_ls_rv[cyc]) cur_ls_rd = e_ls_rd[cyc];
    check_value("if_rdata", if_rdata, cur_if_rd);
    check_value("ls_rdata", ls_rdata, cur_ls_rd);
    check_value("port_overlap", (if_gnt & ls_gnt) | (if_rvalid & ls_rvalid), 0);

    if (if_gnt) begin g_cyc.push_back(cyc); g_ls.push_back(1'b0); end
    if (ls_gnt) begin g_cyc.push_back(cyc); g_ls.push_back(1'b1); end
    if (mem_we != '0) we_cnt++;
    if (if_rvalid) begin
      last_if_rd = if_rdata;
      if_rv_cyc  = cyc;
      $display("txn cycle %0d fetch rdata %h", cyc, if_rdata);
    end
    if (ls_rvalid) begin
      ls_rv_cnt++;
      last_ls_rd = ls_rdata;
      $display("txn cycle %0d lsu rdata %h", cyc, ls_rdata);
    end

    if (e_if_gnt[cyc]) if_pend = 1'b0;
    if (e_ls_gnt[cyc]) ls_pend = 1'b0;
    if (hold_both) begin if_pend = 1'b1; ls_pend = 1'b1; end
    if (rnd) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_addr = 7'($urandom_range(0, 31));
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend  = 1'b1;
        ls_we    = 1'($urandom_range(0, 1));
        ls_be    = 4'($urandom);
        ls_addr  = 7'($urandom_range(0, 31));
        ls_wdata = $urandom;
      end
    end
    if_req = if_pend;
    ls_req = ls_pend;
    if (cyc >= idle_from && (if_pend || ls_pend)) model_grant();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((if_pend || ls_pend || cyc < idle_from) && n < 60) begin
      step(1'b0);
      n++;
    end
    check_value("drain_bound", n < 60, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held while the RAM and its reference copy are loaded
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0);
      ram_init_en   = 1'b1;
      ram_init_addr = 7'(i);
      ram_init_data = (i == 9) ? 32'h1122_3344 : $urandom;
      ref_mem[i]    = ram_init_data;
    end
    step(1'b0);
    ram_init_en = 1'b0;
    rst = 1'b0;
    idle_from = cyc + 1;
    step(1'b0);

    // Fetch only, address 5
    g_cyc.delete(); g_ls.delete();
    c0 = cyc + 1;
    if_pend = 1'b1; if_addr = 7'd5;
    step(1'b0);
    wait_idle();
    check_value("fetch_grants", g_cyc.size(), 1);
    if (g_cyc.size() == 1) check_value("fetch_gnt_lat", g_cyc[0] - c0, 1);
    check_value("fetch_rv_lat", if_rv_cyc - c0, 3);
    check_value("fetch_data", last_if_rd, ref_mem[5]);

    // Partial store then load of the same word
    we_cnt = 0; ls_rv_cnt = 0;
    ls_pend = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 7'd9; ls_wdata = 32'hAABB_CCDD;
    step(1'b0);
    wait_idle();
    check_value("store_we_cycles", we_cnt, 1);
    check_value("store_rvalid", ls_rv_cnt, 1);
    check_value("store_rdata", last_ls_rd, 0);
    ls_pend = 1'b1; ls_we = 1'b0;
    step(1'b0);
    wait_idle();
    check_value("load_after_store", last_ls_rd, 32'h1122_CCDD);

    // Randomized mixed traffic
    repeat (1200) step(1'b1);
    wait_idle();

    // Store with no byte enables
    saved = ref_mem[20];
    we_cnt = 0; ls_rv_cnt = 0;
    ls_pend = 1'b1; ls_we = 1'b1; ls_be = 4'b0000; ls_addr = 7'd20; ls_wdata = ~saved;
    step(1'b0);
    wait_idle();
    check_value("be0_rvalid", ls_rv_cnt, 1);
    check_value("be0_we_cycles", we_cnt, 0);
    check_value("be0_ram", ram[20], saved);

    // Asynchronous reset in the WAIT state of a load
    ls_pend = 1'b1; ls_we = 1'b0; ls_addr = 7'd9;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    #1 rst = 1'b1;
    #1;
    check_value("rst_gnt", {if_gnt, ls_gnt}, 0);
    check_value("rst_rvalid", {if_rvalid, ls_rvalid}, 0);
    check_value("rst_if_rdata", if_rdata, 0);
    check_value("rst_ls_rdata", ls_rdata, 0);
    check_value("rst_mem_ctl", {mem_en, mem_we, mem_addr}, 0);
    check_value("rst_mem_wdata", mem_wdata, 0);
    #1 rst = 1'b0;
    for (int i = cyc + 1; i < NCYC; i++) begin
      e_if_gnt[i] = 0; e_ls_gnt[i] = 0; e_if_rv[i] = 0; e_ls_rv[i] = 0;
      e_en[i] = 0; e_st[i] = 0; e_we[i] = '0;
    end
    cur_if_rd = '0; cur_ls_rd = '0; last_ls = 1'b0; idle_from = cyc + 1;
    ls_rv_cnt = 0;
    repeat (6) step(1'b0);
    check_value("rst_no_rvalid", ls_rv_cnt, 0);

    // Both ports held high: alternating grants, LSU first
    g_cyc.delete(); g_ls.delete();
    if_addr = 7'd3; ls_we = 1'b0; ls_addr = 7'd9;
    hold_both = 1'b1;
    repeat (18) step(1'b0);
    hold_both = 1'b0;
    wait_idle();
    check_value("tie_grants", g_cyc.size() >= 4, 1);
    if (g_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_value("tie_order", g_ls[i], (i % 2) == 0);
        if (i > 0) check_value("tie_spacing", g_cyc[i] - g_cyc[i-1], 4);
      end
    end

    // Three-cycle read latency on u_dut3
    c0 = cyc;
    if_req3 = 1'b1; if_addr3 = 7'd77;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (if_gnt3) begin
        if (t_g < 0) t_g = cyc - c0;
        if_req3 = 1'b0;
      end
      if (mem_en3) begin
        if (t_e < 0) t_e = cyc - c0;
        check_value("l3_mem_addr", mem_addr3, 77);
      end
      if (if_rvalid3) begin
        n_v++;
        if (t_v < 0) t_v = cyc - c0;
        rd3 = if_rdata3;
        $display("txn cycle %0d fetch3 rdata %h wdata %h", cyc, if_rdata3, mem_wdata3);
      end
      check_value("l3_lsu_quiet", {ls_gnt3, ls_rvalid3, mem_we3, |ls_rdata3}, 0);
    end
    check_value("l3_gnt_lat", t_g, 1);
    check_value("l3_en_lat", t_e, 1);
    check_value("l3_rvalid_lat", t_v, 5);
    check_value("l3_rvalid_count", n_v, 1);
    check_value("l3_rdata", rd3, 32'hC0DE_004D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
